// File: rtl/muldiv_sched.sv
// muldiv_sched: sequencer for the shared iterative multiplier/divider.
// Ports: req_* in (valid/ready), mul_*/div_* to units, resp_* out, flush, busy.
module muldiv_sched #(
    parameter int XLEN = 64,
    parameter int CW   = 128
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_kind,
    input  logic            req_signed,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            mul_valid,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    input  logic            mul_done,
    input  logic [CW-1:0]   mul_c,
    output logic            div_valid,
    output logic            div_word,
    output logic [XLEN-1:0] div_a,
    output logic [XLEN-1:0] div_b,
    input  logic            div_done,
    input  logic [CW-1:0]   div_c,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE, MUL_WAIT, DIV_WAIT, RESP, DRAIN
    } state_t;

    state_t          r_state, w_next;
    logic [1:0]      r_kind;
    logic            r_signed, r_word, r_is_div;
    logic            r_mul_valid, r_div_valid;
    logic [XLEN-1:0] r_a, r_b, r_da, r_db, r_resp_data;

    logic            w_accept, w_is_div, w_rem;
    logic            w_sa, w_sb, w_bzero, w_ovf, w_fast;
    logic [XLEN-1:0] w_a_sx, w_fast_data, w_am, w_bm;
    logic            w_ra_s, w_rb_s;
    logic [XLEN-1:0] w_q, w_r, w_qs, w_rs, w_dsel;
    logic [XLEN-1:0] w_div_res, w_mul_res;
    logic            w_unused;

    assign w_unused = ^mul_c[CW-1:XLEN];

    // request decode
    assign w_accept = (r_state == IDLE) & req_valid & ~flush;
    assign w_is_div = (req_kind == 2'b01) | (req_kind == 2'b10);
    assign w_rem    = (req_kind == 2'b10);
    assign w_sa     = req_word ? req_a[31] : req_a[XLEN-1];
    assign w_sb     = req_word ? req_b[31] : req_b[XLEN-1];
    assign w_bzero  = req_word ? (req_b[31:0] == 32'd0)
                               : (req_b == '0);
    assign w_ovf    = req_signed & (req_word
        ? ((req_a[31:0] == 32'h8000_0000) & (&req_b[31:0]))
        : ((req_a == {1'b1, {(XLEN-1){1'b0}}}) & (&req_b)));
    assign w_fast   = w_is_div & (w_bzero | w_ovf);
    assign w_a_sx   = {{(XLEN-32){req_a[31]}}, req_a[31:0]};

    // divide-by-zero wins over overflow (b=0 cannot be -1 anyway)
    always_comb begin
        w_fast_data = '0;
        if (w_bzero)
            w_fast_data = w_rem ? (req_word ? w_a_sx : req_a) : '1;
        else if (!w_rem)
            w_fast_data = req_word ? w_a_sx : req_a;
    end

    // magnitudes; low 32 bits of a 64-bit negate equal the 32-bit negate
    always_comb begin
        w_am = (req_signed & w_sa) ? -req_a : req_a;
        w_bm = (req_signed & w_sb) ? -req_b : req_b;
        if (req_word) begin
            w_am = {{(XLEN-32){1'b0}}, w_am[31:0]};
            w_bm = {{(XLEN-32){1'b0}}, w_bm[31:0]};
        end
    end

    // divider result sign correction
    assign w_ra_s = r_word ? r_a[31] : r_a[XLEN-1];
    assign w_rb_s = r_word ? r_b[31] : r_b[XLEN-1];
    assign w_q = r_word ? {{(XLEN-32){1'b0}}, div_c[31:0]}
                        : div_c[XLEN-1:0];
    assign w_r = r_word ? {{(XLEN-32){1'b0}}, div_c[XLEN+31:XLEN]}
                        : div_c[CW-1:XLEN];
    assign w_qs = (r_signed & (w_ra_s ^ w_rb_s)) ? -w_q : w_q;
    assign w_rs = (r_signed & w_ra_s) ? -w_r : w_r;
    assign w_dsel = (r_kind == 2'b10) ? w_rs : w_qs;
    assign w_div_res = r_word
        ? {{(XLEN-32){w_dsel[31]}}, w_dsel[31:0]} : w_dsel;
    assign w_mul_res = r_word
        ? {{(XLEN-32){mul_c[31]}}, mul_c[31:0]} : mul_c[XLEN-1:0];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!w_is_div)   w_next = MUL_WAIT;
                    else if (w_fast) w_next = RESP;
                    else             w_next = DIV_WAIT;
                end
            end
            MUL_WAIT: begin
                if (mul_done)   w_next = flush ? IDLE : RESP;
                else if (flush) w_next = DRAIN;
            end
            DIV_WAIT: begin
                if (div_done)   w_next = flush ? IDLE : RESP;
                else if (flush) w_next = DRAIN;
            end
            RESP: begin
                if (flush | resp_ready) w_next = IDLE;
            end
            DRAIN: begin
                if (r_is_div ? div_done : mul_done) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_kind      <= 2'b00;
            r_signed    <= 1'b0;
            r_word      <= 1'b0;
            r_is_div    <= 1'b0;
            r_mul_valid <= 1'b0;
            r_div_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_da        <= '0;
            r_db        <= '0;
            r_resp_data <= '0;
        end else begin
            r_state     <= w_next;
            r_mul_valid <= w_accept & ~w_is_div;
            r_div_valid <= w_accept & w_is_div & ~w_fast;
            if (w_accept) begin
                r_kind   <= req_kind;
                r_signed <= req_signed;
                r_word   <= req_word;
                r_is_div <= w_is_div;
                r_a      <= req_a;
                r_b      <= req_b;
                r_da     <= w_am;
                r_db     <= w_bm;
                if (w_fast) r_resp_data <= w_fast_data;
            end
            if ((r_state == MUL_WAIT) && mul_done && !flush)
                r_resp_data <= w_mul_res;
            if ((r_state == DIV_WAIT) && div_done && !flush)
                r_resp_data <= w_div_res;
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_data  = r_resp_data;
    assign mul_valid  = r_mul_valid;
    assign mul_a      = r_a;
    assign mul_b      = r_b;
    assign div_valid  = r_div_valid;
    assign div_word   = r_word;
    assign div_a      = r_da;
    assign div_b      = r_db;

endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: scoreboard bench for muldiv_sched with a
// behavioural multiplier/divider unit of programmable latency.
module tb_muldiv_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready;
    logic [1:0]   req_kind;
    logic         req_signed, req_word;
    logic [63:0]  req_a, req_b;
    logic         flush;
    logic         mul_valid, mul_done;
    logic [63:0]  mul_a, mul_b;
    logic [127:0] mul_c;
    logic         div_valid, div_word, div_done;
    logic [63:0]  div_a, div_b;
    logic [127:0] div_c;
    logic         resp_valid, resp_ready, busy;
    logic [63:0]  resp_data;

    int total = 0;
    int bad = 0;
    int unit_lat = 4;
    logic [63:0] sb[$];

    // observations from the last do_op
    int nm, nd, dc, rc, busy_low;
    logic [63:0] rd, cap_da, cap_db;

    always #5 clk = ~clk;

    muldiv_sched #(.XLEN(64), .CW(128)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_signed(req_signed),
        .req_word(req_word), .req_a(req_a), .req_b(req_b),
        .flush(flush),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_c(mul_c),
        .div_valid(div_valid), .div_word(div_word),
        .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_c(div_c),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .busy(busy)
    );

    // behavioural units: done pulses unit_lat cycles after the start pulse
    initial begin
        int cnt;
        logic m_is_mul;
        logic [127:0] m_res;
        cnt = 0; m_is_mul = 1'b0; m_res = '0;
        mul_done = 1'b0; div_done = 1'b0;
        mul_c = '0; div_c = '0;
        forever begin
            @(posedge clk); #2;
            mul_done = 1'b0;
            div_done = 1'b0;
            if (!reset) cnt = 0;
            else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        if (m_is_mul) begin
                            mul_c = m_res; mul_done = 1'b1;
                        end else begin
                            div_c = m_res; div_done = 1'b1;
                        end
                    end
                end
                if (mul_valid) begin
                    cnt = unit_lat; m_is_mul = 1'b1;
                    m_res = {64'd0, mul_a} * {64'd0, mul_b};
                end
                if (div_valid) begin
                    cnt = unit_lat; m_is_mul = 1'b0;
                    if (div_b == 64'd0) m_res = {div_a, 64'hFFFF_FFFF_FFFF_FFFF};
                    else m_res = {div_a % div_b, div_a / div_b};
                end
            end
        end
    end

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] ref_res(input logic [1:0] k,
        input logic s, input logic w,
        input logic [63:0] a, input logic [63:0] b);
        logic [63:0] p, q, r;
        logic [31:0] a32, b32, q32, r32;
        if (k == 2'b00 || k == 2'b11) begin
            p = a * b;
            return w ? sx32(p[31:0]) : p;
        end
        if (w) begin
            a32 = a[31:0]; b32 = b[31:0];
            if (b32 == 0) begin q32 = '1; r32 = a32; end
            else if (s && a32 == 32'h8000_0000 && b32 == '1) begin
                q32 = a32; r32 = 0;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            return (k == 2'b01) ? sx32(q32) : sx32(r32);
        end
        if (b == 0) begin q = '1; r = a; end
        else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a; r = 0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b; r = a % b;
        end
        return (k == 2'b01) ? q : r;
    endfunction

    function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0: v = 64'd0;
            1: v = '1;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'h0000_0000_8000_0000;
            4: v = 64'($urandom_range(1, 20));
            5: v = 64'd0 - 64'($urandom_range(1, 20));
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    // drive one request; returns at the first negedge after acceptance
    task automatic issue(input logic [1:0] k, input logic s,
        input logic w, input logic [63:0] a, input logic [63:0] b,
        input bit push);
        int n;
        @(negedge clk);
        req_kind = k; req_signed = s; req_word = w;
        req_a = a; req_b = b; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk); n++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL issue_timeout req_ready=%0b required=1", req_ready);
        end
        if (push) sb.push_back(ref_res(k, s, w, a, b));
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // issue, follow to the response, then accept it
    task automatic do_op(input logic [1:0] k, input logic s,
        input logic w, input logic [63:0] a, input logic [63:0] b);
        nm = 0; nd = 0; dc = -1; rc = -1; busy_low = 0;
        rd = '0; cap_da = '0; cap_db = '0;
        issue(k, s, w, a, b, 1'b1);
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) @(negedge clk);
            if (mul_valid) nm++;
            if (div_valid) nd++;
            if (c == 1) begin cap_da = div_a; cap_db = div_b; end
            if (mul_done || div_done) dc = c;
            if (!busy) busy_low++;
            if (resp_valid) begin rc = c; rd = resp_data; break; end
        end
        if (rc < 0) begin
            total++; bad++;
            $display("FAIL resp_timeout resp_valid=0 required=1");
        end else begin
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin bad++;
            $display("FAIL rst_req_ready got=%0b required=1", req_ready); end
        total++;
        if ({resp_valid, busy, mul_valid, div_valid} !== 4'b0) begin bad++;
            $display("FAIL rst_ctrl got=%b required=0000",
                {resp_valid, busy, mul_valid, div_valid}); end
        total++;
        if ({resp_data, mul_a, div_a, div_b} !== 256'd0) begin bad++;
            $display("FAIL rst_data got=%h/%h/%h required=0",
                resp_data, mul_a, div_a); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [63:0] exp;
        unit_lat = 4;
        do_op(2'b00, 1'b0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE);
        exp = sb.size() > 0 ? sb.pop_front() : 64'hx;
        total++;
        if (rd !== exp) begin bad++;
            $display("FAIL mul_data got=%h required=%h", rd, exp); end
        total++;
        if (exp !== 64'hFFFF_FFFF_FFFF_FFFA) begin bad++;
            $display("FAIL mul_model got=%h required=fffffffffffffffa", exp); end
        total++;
        if (nm !== 1 || nd !== 0) begin bad++;
            $display("FAIL mul_pulses got=%0d/%0d required=1/0", nm, nd); end
        total++;
        if (rc !== dc + 1 || dc !== 5) begin bad++;
            $display("FAIL mul_latency got=done%0d/resp%0d required=5/6", dc, rc); end
        total++;
        if (busy_low !== 0) begin bad++;
            $display("FAIL mul_busy got=%0d low cycles required=0", busy_low); end
    endtask

    task automatic test_div_signed();
        logic [63:0] exp;
        unit_lat = 3;
        for (int i = 0; i < 2; i++) begin
            do_op(i == 0 ? 2'b01 : 2'b10, 1'b1, 1'b0,
                  64'd0 - 64'd7, 64'd2);
            exp = sb.size() > 0 ? sb.pop_front() : 64'hx;
            total++;
            if (rd !== exp) begin bad++;
                $display("FAIL sdiv_data[%0d] got=%h required=%h", i, rd, exp); end
            total++;
            if (cap_da !== 64'd7 || cap_db !== 64'd2 || nd !== 1) begin bad++;
                $display("FAIL sdiv_operands[%0d] got=%0d/%0d/%0d required=7/2/1",
                    i, cap_da, cap_db, nd); end
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] exp;
        for (int i = 0; i < 2; i++) begin
            do_op(i == 0 ? 2'b01 : 2'b10, 1'b1, 1'b1,
                  64'h0000_0000_8000_0001, 64'h1234_5678_0000_0000);
            exp = sb.size() > 0 ? sb.pop_front() : 64'hx;
            total++;
            if (rd !== exp) begin bad++;
                $display("FAIL dz_data[%0d] got=%h required=%h", i, rd, exp); end
            total++;
            if (nd !== 0 || rc !== 1) begin bad++;
                $display("FAIL dz_fast[%0d] got=pulses%0d/resp%0d required=0/1",
                    i, nd, rc); end
        end
    endtask

    task automatic test_overflow();
        logic [63:0] exp;
        for (int i = 0; i < 2; i++) begin
            do_op(i == 0 ? 2'b01 : 2'b10, 1'b1, 1'b0,
                  64'h8000_0000_0000_0000, '1);
            exp = sb.size() > 0 ? sb.pop_front() : 64'hx;
            total++;
            if (rd !== exp) begin bad++;
                $display("FAIL ovf_data[%0d] got=%h required=%h", i, rd, exp); end
            total++;
            if (nd !== 0 || rc !== 1) begin bad++;
                $display("FAIL ovf_fast[%0d] got=pulses%0d/resp%0d required=0/1",
                    i, nd, rc); end
        end
    endtask

    task automatic test_flush_drain();
        int viol, dseen, n;
        unit_lat = 7;
        issue(2'b01, 1'b0, 1'b0, 64'd100, 64'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin bad++;
            $display("FAIL drain_enter got=busy%0b/ready%0b required=1/0",
                busy, req_ready); end
        req_kind = 2'b00; req_a = 64'd9; req_b = 64'd9; req_valid = 1'b1;
        viol = 0; dseen = -1;
        for (int c = 4; c < 24; c++) begin
            if (c > 4) @(negedge clk);
            flush = (c == 5);
            if (div_done) begin dseen = c; break; end
            if (req_ready || resp_valid || mul_valid) viol++;
        end
        req_valid = 1'b0; flush = 1'b0;
        total++;
        if (viol !== 0 || dseen !== 8) begin bad++;
            $display("FAIL drain_wait got=viol%0d/done%0d required=0/8", viol, dseen); end
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++;
            $display("FAIL drain_exit got=ready%0b/resp%0b required=1/0",
                req_ready, resp_valid); end
        // flush in the same cycle as done
        unit_lat = 3;
        issue(2'b10, 1'b1, 1'b0, 64'd50, 64'd3, 1'b0);
        n = 0;
        while (!div_done && n < 20) begin @(negedge clk); n++; end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || n >= 20) begin bad++;
            $display("FAIL flush_done got=busy%0b/resp%0b required=0/0",
                busy, resp_valid); end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp;
        int hb, n;
        unit_lat = 2;
        issue(2'b00, 1'b0, 1'b0, 64'd5, 64'd6, 1'b1);
        n = 0;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        exp = sb.size() > 0 ? sb.pop_front() : 64'hx;
        total++;
        if (resp_valid !== 1'b1 || resp_data !== exp) begin bad++;
            $display("FAIL bp_first got=%0b/%h required=1/%h",
                resp_valid, resp_data, exp); end
        req_kind = 2'b01; req_a = 64'd1; req_b = 64'd1; req_valid = 1'b1;
        hb = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_data !== exp || req_ready) hb++;
        end
        total++;
        if (hb !== 0) begin bad++;
            $display("FAIL bp_hold got=%0d bad cycles required=0", hb); end
        req_valid = 1'b0; resp_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0; flush = 1'b0;
        total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL bp_flush got=resp%0b/busy%0b required=0/0",
                resp_valid, busy); end
    endtask

    task automatic test_reset_midop();
        int seen;
        unit_lat = 5;
        issue(2'b01, 1'b0, 1'b0, 64'd100, 64'd7, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || div_a !== 64'd0) begin bad++;
            $display("FAIL midrst got=busy%0b/ready%0b/%h required=0/1/0",
                busy, req_ready, div_a); end
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid || busy) seen++;
        end
        total++;
        if (seen !== 0) begin bad++;
            $display("FAIL midrst_quiet got=%0d required=0", seen); end
    endtask

    task automatic test_mix();
        logic [63:0] a, b, exp;
        logic [1:0] k;
        logic s, w;
        for (int i = 0; i < 60; i++) begin
            k = 2'($urandom_range(0, 3));
            s = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = pick(); b = pick();
            unit_lat = $urandom_range(1, 5);
            do_op(k, s, w, a, b);
            exp = sb.size() > 0 ? sb.pop_front() : 64'hx;
            total++;
            if (rd !== exp) begin bad++;
                $display("FAIL mix[%0d] k=%0d s=%0b w=%0b a=%h b=%h got=%h required=%h",
                    i, k, s, w, a, b, rd, exp); end
        end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_kind = 2'b00;
        req_signed = 1'b0; req_word = 1'b0; req_a = '0; req_b = '0;
        flush = 1'b0; resp_ready = 1'b0;
        test_reset();
        test_mul();
        test_div_signed();
        test_div_zero();
        test_overflow();
        test_flush_drain();
        test_backpressure();
        test_reset_midop();
        test_mix();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Sequencer for the shared iterative multiplier and divider used by the execute stage.
- Accepts one mul/div/rem request at a time and latches its operands.
- Divides: performs sign pre-conditioning (magnitudes to the unsigned divider), issues a single start pulse to the unit, then sign-corrects and selects the result.
- Presents the result on a valid/ready response port; handles divide-by-zero and signed-overflow fast paths, pipeline flush and abort-drain.

Parameters:
XLEN, 64, operand/result width
CW, 128, unit result width (2*XLEN)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-low (asserted when 0)
req_valid  in  1  request present
req_ready  out  1  scheduler can accept
req_kind  in  2  00 MUL (low product), 01 DIV (quotient), 10 REM (remainder), 11 reserved (treated as MUL)
req_signed  in  1  signed division; ignored for MUL
req_word  in  1  32-bit op, result sign-extended from bit 31
req_a  in  XLEN  operand a
req_b  in  XLEN  operand b
flush  in  1  kill in-flight/pending op
mul_valid  out  1  one-cycle start pulse to multiplier
mul_a, mul_b  out  XLEN  latched operands
mul_done  in  1  multiplier result valid
mul_c  in  CW  product
div_valid  out  1  one-cycle start pulse to divider
div_word  out  1  word mode to divider
div_a, div_b  out  XLEN  unsigned magnitudes (word: zero-extended 32-bit magnitudes)
div_done  in  1  divider result valid
div_c  in  CW  {remainder, quotient}, unsigned
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts
resp_data  out  XLEN  result
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0 except req_ready=1. Latched operands cleared.
- States: IDLE, MUL_WAIT, DIV_WAIT, RESP, DRAIN. req_ready=1 only in IDLE.
- IDLE, on req_valid & ~flush: latch kind/signed/word/a/b, then branch:
  - MUL -> MUL_WAIT.
  - DIV/REM with effective divisor 0 (word: b[31:0]==0) -> RESP. Quotient = all ones; remainder = a (word: sext a[31:0]).
  - Signed with a = most-negative and b = -1 (per width) -> RESP. Quotient = a; remainder = 0.
  - Other DIV/REM -> DIV_WAIT.
- IDLE, req_valid & flush: request not accepted; stay IDLE.
- Start pulses: mul_valid / div_valid are registered and high exactly in the first cycle of MUL_WAIT / DIV_WAIT, never otherwise.
- Unit operands: mul_*/div_* held stable from the start pulse until done.
  - Signed magnitude: negate if sign bit (bit 63, or bit 31 for word) is set.
  - Unsigned: pass through (word: zero-extend low 32).
- MUL_WAIT, on mul_done: resp_data <= word ? sext(mul_c[31:0]) : mul_c[63:0]; go RESP.
- DIV_WAIT, on div_done: take q = div_c[63:0], r = div_c[127:64] (word: low 32 of each).
  - Signed: negate q if sign(a) != sign(b); negate r if sign(a).
  - Select q (DIV) or r (REM); word results sign-extended from bit 31; registered into resp_data; go RESP.
- Done pulses arriving in any state other than the matching WAIT/DRAIN are ignored.
- RESP: resp_valid=1, resp_data stable. On resp_ready -> IDLE (no same-cycle new accept).
- Flush:
  - In WAIT with done low -> DRAIN.
  - In WAIT with done high the same cycle -> IDLE, result discarded.
  - In RESP -> IDLE, resp_valid drops next cycle.
  - Flush takes priority over resp_ready.
- DRAIN: wait for the in-flight unit's done; then IDLE, result discarded; no pulse issued. Further flush has no effect.
- Latency:
  - Fast path: accept at cycle 0 -> resp_valid at cycle 1.
  - Unit path: start pulse at cycle 1; done seen at cycle N -> resp_valid at N+1.
- Throughput: one op outstanding. Back-to-back issue needs ≥1 IDLE cycle after the response handshake.
- Reset mid-operation: immediate return to IDLE and reset output values. Units are reset by the same reset; no drain.

Test Plan:
- MUL a=3, b=-2 (0xFFFF_FFFF_FFFF_FFFE), unit returns 128-bit product after 4 cycles -> exactly one mul_valid pulse; resp_data=0xFFFF_FFFF_FFFF_FFFA one cycle after mul_done; busy high throughout.
- Signed DIV/REM, a=-7, b=2 -> div_a=7, div_b=2; unit returns q=3, r=1; DIV gives resp_data=-3; REM gives -1.
- Word signed DIV, b[31:0]=0, a=0x0000_0000_8000_0001 -> no div_valid; resp_valid at cycle 1. DIV gives 0xFFFF_FFFF_FFFF_FFFF; REM gives 0xFFFF_FFFF_8000_0001.
- Signed DIV a=0x8000_0000_0000_0000, b=-1 -> no div_valid; quotient 0x8000_0000_0000_0000; REM gives 0.
- Flush 2 cycles after div_valid, div_done 5 cycles later -> state DRAIN, req_ready=0 until div_done, then IDLE; no resp_valid.
- Response backpressure: resp_ready low 3 cycles -> resp_valid/resp_data held, new req_valid not accepted. Then flush together with resp_ready -> IDLE, result dropped.
